// File: rtl/fxp_mac_array.sv
// fxp_mac_array: LANES-wide signed fixed-point multiply-accumulate over
// in_last-delimited windows, with round-half-even and saturation to DATA_W.
// Optional macro FXP_MAC_RELU_EN clamps negative results to zero.
module fxp_mac_array #(
   parameter int DATA_W    = 14,
   parameter int FRAC_BITS = 7,
   parameter int LANES     = 2,
   parameter int ACC_GUARD = 8,
   parameter int CNT_W     = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic                     in_last,
   input  logic [LANES*DATA_W-1:0]  a,
   input  logic [LANES*DATA_W-1:0]  b,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_result,
   output logic                     out_sat,
   output logic [CNT_W-1:0]         out_count
);

   localparam int PROD_W = 2 * DATA_W;
   localparam int ACC_W  = PROD_W + $clog2(LANES) + ACC_GUARD;
   localparam logic signed [ACC_W-1:0] RES_MAX = (ACC_W'(1) << (DATA_W - 1)) - ACC_W'(1);
   localparam logic signed [ACC_W-1:0] RES_MIN = ~RES_MAX;

   logic signed [DATA_W-1:0] lane_a [LANES];
   logic signed [DATA_W-1:0] lane_b [LANES];
   logic signed [PROD_W-1:0] s1_prod [LANES];
   logic                     s1_valid, s1_last;

   logic signed [ACC_W-1:0]  lane_sum, acc, acc_next, s2_acc;
   logic [CNT_W-1:0]         cnt, cnt_next, s2_cnt;
   logic                     first, s2_valid;

   logic signed [ACC_W-1:0]  q, q_rnd;
   logic                     rnd_r, rnd_s, res_sat;
   logic [DATA_W-1:0]        res;

   // unpack lane operands
   always_comb begin
      for (int unsigned i = 0; i < LANES; i++) begin
         lane_a[i] = a[i*DATA_W +: DATA_W];
         lane_b[i] = b[i*DATA_W +: DATA_W];
      end
   end

   // S1: register full-width lane products and beat flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         for (int unsigned i = 0; i < LANES; i++) s1_prod[i] <= '0;
      end else begin
         s1_valid <= in_valid;
         s1_last  <= in_valid & in_last;
         if (in_valid) begin
            for (int unsigned i = 0; i < LANES; i++)
               s1_prod[i] <= PROD_W'(lane_a[i]) * PROD_W'(lane_b[i]);
         end
      end
   end

   // S2 combinational: lane sum, window accumulate, saturating beat count
   always_comb begin
      lane_sum = '0;
      for (int unsigned i = 0; i < LANES; i++)
         lane_sum = lane_sum + ACC_W'(s1_prod[i]);
      acc_next = (first ? '0 : acc) + lane_sum;
      if (first)      cnt_next = CNT_W'(1);
      else if (&cnt) cnt_next = cnt;
      else            cnt_next = cnt + CNT_W'(1);
   end

   // S2: accumulator state; hand off to S3 and restart window on last beat
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc      <= '0;
         cnt      <= '0;
         first    <= 1'b1;
         s2_valid <= 1'b0;
         s2_acc   <= '0;
         s2_cnt   <= '0;
      end else begin
         s2_valid <= s1_valid & s1_last;
         if (s1_valid) begin
            if (s1_last) begin
               s2_acc <= acc_next;
               s2_cnt <= cnt_next;
               acc    <= '0;
               cnt    <= '0;
               first  <= 1'b1;
            end else begin
               acc    <= acc_next;
               cnt    <= cnt_next;
               first  <= 1'b0;
            end
         end
      end
   end

   // S3 combinational: round-half-even, saturate, optional ReLU clamp
   always_comb begin
      q       = s2_acc >>> FRAC_BITS;
      rnd_r   = s2_acc[FRAC_BITS-1];
      rnd_s   = |s2_acc[FRAC_BITS-2:0];
      q_rnd   = q + ACC_W'(rnd_r & (rnd_s | q[0]));
      res_sat = 1'b0;
      res     = q_rnd[DATA_W-1:0];
      if (q_rnd > RES_MAX) begin
         res     = {1'b0, {(DATA_W-1){1'b1}}};
         res_sat = 1'b1;
      end else if (q_rnd < RES_MIN) begin
         res     = {1'b1, {(DATA_W-1){1'b0}}};
         res_sat = 1'b1;
      end
`ifdef FXP_MAC_RELU_EN
      if (res[DATA_W-1]) res = '0;
`else
`endif
   end

   // S3: output registers, held between result pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid  <= 1'b0;
         out_result <= '0;
         out_sat    <= 1'b0;
         out_count  <= '0;
      end else begin
         out_valid <= s2_valid;
         if (s2_valid) begin
            out_result <= res;
            out_sat    <= res_sat;
            out_count  <= s2_cnt;
         end
      end
   end

endmodule

// File: tb/tb_fxp_mac_array.sv
// Directed bench for fxp_mac_array: single-beat vector table plus
// multi-beat window, back-to-back, count saturation and reset sequences.
module tb_fxp_mac_array;

   localparam int DW = 14;
   localparam int CW = 8;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_last = 1'b0;
   logic [2*DW-1:0] a = '0;
   logic [2*DW-1:0] b = '0;
   logic            out_valid, out_sat;
   logic [DW-1:0]   out_result;
   logic [CW-1:0]   out_count;

   fxp_mac_array #(
      .DATA_W(14), .FRAC_BITS(7), .LANES(2), .ACC_GUARD(8), .CNT_W(8)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
      .a(a), .b(b), .out_valid(out_valid), .out_result(out_result),
      .out_sat(out_sat), .out_count(out_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   logic [DW-1:0] q_res [$];
   logic          q_sat [$];
   logic [CW-1:0] q_cnt [$];
   int            q_cyc [$];

   always @(negedge clk) begin
      if (rst && out_valid) begin
         q_res.push_back(out_result);
         q_sat.push_back(out_sat);
         q_cnt.push_back(out_count);
         q_cyc.push_back(cyc);
      end
   end

   int errors = 0;
   int checks = 0;
   int last_edge = 0;

   typedef struct {
      string name;
      int    a0, a1, b0, b1;
      int    res, sat, cnt;
   } vec_t;

   vec_t vecs [9];

   function automatic int relu(input int x);
`ifdef FXP_MAC_RELU_EN
      return (x < 0) ? 0 : x;
`else
      return x;
`endif
   endfunction

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic clear_q();
      q_res.delete(); q_sat.delete(); q_cnt.delete(); q_cyc.delete();
   endtask

   task automatic beat(input int a0, input int a1, input int b0, input int b1,
                       input bit last, input bit vld);
      @(negedge clk);
      in_valid = vld;
      in_last  = last;
      a = {DW'(a1), DW'(a0)};
      b = {DW'(b1), DW'(b0)};
      if (vld && last) last_edge = cyc + 1;
   endtask

   task automatic settle();
      repeat (6) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_last  = 1'b0;
      end
      #1;
   endtask

   task automatic expect_pulse(input string nm, input int idx, input int res,
                               input int sat, input int cnt, input int at);
      if (idx < q_res.size()) begin
         chk({nm, "_res"}, int'($signed(q_res[idx])), res);
         chk({nm, "_sat"}, int'(q_sat[idx]), sat);
         chk({nm, "_cnt"}, int'(q_cnt[idx]), cnt);
         chk({nm, "_cycle"}, q_cyc[idx], at);
      end else begin
         chk({nm, "_present"}, q_res.size(), idx + 1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      int e;

      vecs[0] = '{"basic",     128,   256,   128,  64,   256,           0, 1};
      vecs[1] = '{"tie_even0", 1,     0,     64,   0,    0,             0, 1};
      vecs[2] = '{"tie_even2", 3,     0,     64,   0,    2,             0, 1};
      vecs[3] = '{"round_up",  1,     0,     96,   0,    1,             0, 1};
      vecs[4] = '{"neg_tie0",  -1,    0,     64,   0,    0,             0, 1};
      vecs[5] = '{"neg_tie2",  -3,    0,     64,   0,    relu(-2),      0, 1};
      vecs[6] = '{"max_exact", 8191,  0,     128,  0,    8191,          0, 1};
      vecs[7] = '{"min_exact", -8192, 0,     128,  0,    relu(-8192),   0, 1};
      vecs[8] = '{"neg_sat",   -8192, -8192, 8191, 8191, relu(-8192),   1, 1};

      repeat (3) @(negedge clk);
      chk("reset_valid",  int'(out_valid), 0);
      chk("reset_result", int'(out_result), 0);
      chk("reset_sat",    int'(out_sat), 0);
      chk("reset_count",  int'(out_count), 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // single-beat table
      for (int i = 0; i < 9; i++) begin
         clear_q();
         beat(vecs[i].a0, vecs[i].a1, vecs[i].b0, vecs[i].b1, 1'b1, 1'b1);
         e = last_edge;
         settle();
         chk({vecs[i].name, "_npulse"}, q_res.size(), 1);
         expect_pulse(vecs[i].name, 0, vecs[i].res, vecs[i].sat, vecs[i].cnt, e + 2);
         chk({vecs[i].name, "_idle_valid"}, int'(out_valid), 0);
         chk({vecs[i].name, "_hold_res"}, int'($signed(out_result)), vecs[i].res);
      end

      // two-beat positive saturation
      clear_q();
      beat(8191, 8191, 8191, 8191, 1'b0, 1'b1);
      beat(8191, 8191, 8191, 8191, 1'b1, 1'b1);
      e = last_edge;
      settle();
      chk("pos_sat_npulse", q_res.size(), 1);
      expect_pulse("pos_sat", 0, 8191, 1, 2, e + 2);

      // back-to-back windows, bubble carrying a stray in_last
      clear_q();
      beat(128, 128, 128, 128, 1'b0, 1'b1);
      beat(128, 128, 128, 128, 1'b0, 1'b1);
      beat(0, 0, 0, 0, 1'b1, 1'b0);
      beat(128, 128, 128, 128, 1'b1, 1'b1);
      e = last_edge;
      beat(64, 0, -128, 0, 1'b1, 1'b1);
      settle();
      chk("b2b_npulse", q_res.size(), 2);
      expect_pulse("winA", 0, 768, 0, 3, e + 2);
      expect_pulse("winB", 1, relu(-64), 0, 1, e + 3);

      // beat counter saturation over a 300-beat window
      clear_q();
      for (int i = 0; i < 299; i++) beat(1, 0, 1, 0, 1'b0, 1'b1);
      beat(1, 0, 1, 0, 1'b1, 1'b1);
      e = last_edge;
      settle();
      chk("cnt_sat_npulse", q_res.size(), 1);
      expect_pulse("cnt_sat", 0, 2, 0, 255, e + 2);

      // reset mid-window discards the partial window
      clear_q();
      beat(128, 128, 128, 128, 1'b0, 1'b1);
      beat(128, 128, 128, 128, 1'b0, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("midrst_count_cleared", int'(out_count), 0);
      chk("midrst_result_cleared", int'(out_result), 0);
      @(negedge clk);
      rst = 1'b1;
      beat(128, 0, 128, 0, 1'b1, 1'b1);
      e = last_edge;
      settle();
      chk("midrst_npulse", q_res.size(), 1);
      expect_pulse("midrst", 0, 128, 0, 1, e + 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
